// File: rtl/branch_resolver.sv
// Control-transfer resolver: decodes JAL/JALR/BRANCH, registers taken flag, PC offset and link value.
// Optional macro BRANCH_STATS_EN adds stat_branches/stat_taken counters.
module branch_resolver #(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [31:0]     INSTR,
  input  logic [XLEN-1:0] IP,
  input  logic [XLEN-1:0] RS1_VAL,
  input  logic [XLEN-1:0] RS2_VAL,
  output logic            b_taken,
  output logic [XLEN-1:0] up_amt,
  output logic            link_we,
  output logic [XLEN-1:0] link_data,
  output logic            busy,
`ifdef BRANCH_STATS_EN
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_taken,
`endif
  output logic            illegal
);

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {IDLE, RESOLVE, HOLD} state_t;

  function automatic logic signed [31:0] b_imm(input logic [31:0] ins);
    return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  endfunction

  function automatic logic signed [31:0] j_imm(input logic [31:0] ins);
    return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
  endfunction

  function automatic logic signed [31:0] i_imm(input logic [31:0] ins);
    return {{20{ins[31]}}, ins[31:20]};
  endfunction

  // Offset relative to IP so the PC unit can always add up_amt to IP; wraps mod 2^32.
  function automatic logic signed [31:0] jalr_off(input logic [31:0] rs1,
                                                  input logic [31:0] ins,
                                                  input logic [31:0] ip);
    logic [31:0] tgt;
    tgt = (rs1 + i_imm(ins)) & ~32'd1;
    return tgt - ip;
  endfunction

  state_t state_p1, state_d;

  logic [6:0]             op;
  logic [2:0]             f3;
  logic                   is_jal, is_jalr, is_br, is_ctrl;
  logic signed [XLEN-1:0] rs1_s, rs2_s;
  logic                   cond, br_ill;
  logic                   cap_taken;
  logic signed [XLEN-1:0] cap_amt;

  logic                   taken_d, lwe_d, ill_d;
  logic [XLEN-1:0]        amt_d, ldata_d;

  assign op      = INSTR[6:0];
  assign f3      = INSTR[14:12];
  assign is_jal  = (op == OP_JAL);
  assign is_jalr = (op == OP_JALR);
  assign is_br   = (op == OP_BRANCH);
  assign is_ctrl = is_jal | is_jalr | is_br;
  assign rs1_s   = RS1_VAL;
  assign rs2_s   = RS2_VAL;
  assign br_ill  = (f3[2:1] == 2'b01);

  always_comb begin
    cond = 1'b0;
    unique case (f3)
      3'b000:  cond = (RS1_VAL == RS2_VAL);
      3'b001:  cond = (RS1_VAL != RS2_VAL);
      3'b100:  cond = (rs1_s <  rs2_s);
      3'b101:  cond = (rs1_s >= rs2_s);
      3'b110:  cond = (RS1_VAL <  RS2_VAL);
      3'b111:  cond = (RS1_VAL >= RS2_VAL);
      default: cond = 1'b0;
    endcase
  end

  always_comb begin
    cap_taken = 1'b0;
    cap_amt   = '0;
    if (is_jal) begin
      cap_taken = 1'b1;
      cap_amt   = j_imm(INSTR);
    end else if (is_jalr) begin
      cap_taken = 1'b1;
      cap_amt   = jalr_off(RS1_VAL, INSTR, IP);
    end else if (is_br && !br_ill) begin
      cap_taken = cond;
      cap_amt   = b_imm(INSTR);
    end
  end

  always_comb begin
    state_d = state_p1;
    taken_d = b_taken;
    amt_d   = up_amt;
    lwe_d   = link_we;
    ldata_d = link_data;
    ill_d   = illegal;
    unique case (state_p1)
      IDLE: begin
        if (is_ctrl) begin
          state_d = RESOLVE;
          taken_d = cap_taken;
          amt_d   = cap_amt;
          lwe_d   = is_jal | is_jalr;
          ldata_d = IP + 32'd4;
          ill_d   = is_br & br_ill;
        end else begin
          taken_d = 1'b0;
          amt_d   = '0;
          lwe_d   = 1'b0;
          ill_d   = 1'b0;
        end
      end
      RESOLVE: begin
        lwe_d = 1'b0;
        ill_d = 1'b0;
        if (b_taken) begin
          state_d = HOLD;
        end else begin
          state_d = IDLE;
          amt_d   = '0;
        end
      end
      HOLD: begin
        state_d = IDLE;
        taken_d = 1'b0;
        amt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture / result register stage
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_p1  <= IDLE;
      b_taken   <= 1'b0;
      up_amt    <= '0;
      link_we   <= 1'b0;
      link_data <= '0;
      illegal   <= 1'b0;
    end else begin
      state_p1  <= state_d;
      b_taken   <= taken_d;
      up_amt    <= amt_d;
      link_we   <= lwe_d;
      link_data <= ldata_d;
      illegal   <= ill_d;
    end
  end

  assign busy = (state_p1 != IDLE);

`ifdef BRANCH_STATS_EN
  logic br_p1;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      br_p1         <= 1'b0;
      stat_branches <= '0;
      stat_taken    <= '0;
    end else begin
      if (state_p1 == IDLE && is_ctrl) begin
        br_p1 <= is_br;
      end
      if (state_p1 == IDLE && is_br) begin
        stat_branches <= stat_branches + 32'd1;
      end
      if (state_p1 == RESOLVE && b_taken && br_p1) begin
        stat_taken <= stat_taken + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver: hand-encoded instructions, immediate assertions per check.
module tb_branch_resolver;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [31:0] INSTR = 32'h0000_0013;
  logic [31:0] IP = '0;
  logic [31:0] RS1_VAL = '0;
  logic [31:0] RS2_VAL = '0;
  logic        b_taken, link_we, busy, illegal;
  logic [31:0] up_amt, link_data;
`ifdef BRANCH_STATS_EN
  logic [31:0] stat_branches, stat_taken;
`endif

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] BEQ_M8   = 32'hFE00_0CE3;
  localparam logic [31:0] BNE_16   = 32'h0000_1863;
  localparam logic [31:0] ILL_16   = 32'h0000_2863;
  localparam logic [31:0] BLT_16   = 32'h0000_4863;
  localparam logic [31:0] BLTU_16  = 32'h0000_6863;
  localparam logic [31:0] BGEU_16  = 32'h0000_7863;
  localparam logic [31:0] JALR_4   = 32'h0040_0067;
  localparam logic [31:0] JAL_8    = 32'h0080_006F;

  branch_resolver #(.XLEN(32)) dut (
    .CLK(CLK), .RESET(RESET), .INSTR(INSTR), .IP(IP),
    .RS1_VAL(RS1_VAL), .RS2_VAL(RS2_VAL),
    .b_taken(b_taken), .up_amt(up_amt), .link_we(link_we),
    .link_data(link_data), .busy(busy),
`ifdef BRANCH_STATS_EN
    .stat_branches(stat_branches), .stat_taken(stat_taken),
`endif
    .illegal(illegal)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [31:0] ins, input logic [31:0] ip,
                       input logic [31:0] a, input logic [31:0] b);
    INSTR = ins; IP = ip; RS1_VAL = a; RS2_VAL = b;
  endtask

  initial begin
    tick(); tick();
    chk("rst_taken", {31'd0, b_taken}, 32'd0);
    chk("rst_amt", up_amt, 32'd0);
    chk("rst_lwe", {31'd0, link_we}, 32'd0);
    chk("rst_ldata", link_data, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ill", {31'd0, illegal}, 32'd0);
    #4 RESET = 1'b1;

    // JAL interrupted by reset mid-RESOLVE
    issue(JAL_8, 32'h200, 32'd0, 32'd0);
    tick();
    chk("jal_busy", {31'd0, busy}, 32'd1);
    chk("jal_lwe", {31'd0, link_we}, 32'd1);
    INSTR = NOP;
    #2 RESET = 1'b0;
    #1;
    chk("arst_taken", {31'd0, b_taken}, 32'd0);
    chk("arst_amt", up_amt, 32'd0);
    chk("arst_lwe", {31'd0, link_we}, 32'd0);
    chk("arst_ldata", link_data, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    #1 RESET = 1'b1;

    // Taken BEQ, offset -8
    issue(BEQ_M8, 32'h100, 32'd5, 32'd5);
    tick();
    chk("beq_taken", {31'd0, b_taken}, 32'd1);
    chk("beq_amt", up_amt, 32'hFFFF_FFF8);
    chk("beq_busy", {31'd0, busy}, 32'd1);
    chk("beq_lwe", {31'd0, link_we}, 32'd0);
    INSTR = NOP;
    tick();
    chk("beq_hold_taken", {31'd0, b_taken}, 32'd1);
    chk("beq_hold_amt", up_amt, 32'hFFFF_FFF8);
    chk("beq_hold_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("beq_end_taken", {31'd0, b_taken}, 32'd0);
    chk("beq_end_amt", up_amt, 32'd0);
    chk("beq_end_busy", {31'd0, busy}, 32'd0);

    // BLTU not taken: 0xFFFFFFFF is large unsigned
    issue(BLTU_16, 32'h300, 32'hFFFF_FFFF, 32'd1);
    tick();
    chk("bltu_taken", {31'd0, b_taken}, 32'd0);
    chk("bltu_amt", up_amt, 32'h10);
    INSTR = NOP;
    tick();
    chk("bltu_busy", {31'd0, busy}, 32'd0);
    chk("bltu_amt_clr", up_amt, 32'd0);
`ifdef BRANCH_STATS_EN
    chk("stat_br_2", stat_branches, 32'd2);
    chk("stat_tk_1", stat_taken, 32'd1);
`endif

    // BLT same operands: -1 < 1 signed
    issue(BLT_16, 32'h300, 32'hFFFF_FFFF, 32'd1);
    tick();
    chk("blt_taken", {31'd0, b_taken}, 32'd1);
    chk("blt_amt", up_amt, 32'h10);
    INSTR = NOP;
    tick(); tick();
    chk("blt_busy", {31'd0, busy}, 32'd0);

    issue(BNE_16, 32'h300, 32'd5, 32'd5);
    tick();
    chk("bne_taken", {31'd0, b_taken}, 32'd0);
    INSTR = NOP;
    tick();

    issue(BGEU_16, 32'h300, 32'hFFFF_FFFF, 32'd1);
    tick();
    chk("bgeu_taken", {31'd0, b_taken}, 32'd1);
    INSTR = NOP;
    tick(); tick();

    // JALR: ((0x203 + 4) & ~1) - 0x100
    issue(JALR_4, 32'h100, 32'h203, 32'd0);
    tick();
    chk("jalr_taken", {31'd0, b_taken}, 32'd1);
    chk("jalr_amt", up_amt, 32'h106);
    chk("jalr_lwe", {31'd0, link_we}, 32'd1);
    chk("jalr_ldata", link_data, 32'h104);
    INSTR = NOP;
    tick();
    chk("jalr_lwe_off", {31'd0, link_we}, 32'd0);
    chk("jalr_hold_amt", up_amt, 32'h106);
    tick();

    // JAL with IP+4 wrapping
    issue(JAL_8, 32'hFFFF_FFFC, 32'd0, 32'd0);
    tick();
    chk("jalw_ldata", link_data, 32'h0);
    chk("jalw_lwe", {31'd0, link_we}, 32'd1);
    chk("jalw_amt", up_amt, 32'h8);
    INSTR = NOP;
    tick(); tick();

    // funct3 010
    issue(ILL_16, 32'h300, 32'd5, 32'd5);
    tick();
    chk("ill_pulse", {31'd0, illegal}, 32'd1);
    chk("ill_taken", {31'd0, b_taken}, 32'd0);
    chk("ill_amt", up_amt, 32'd0);
    INSTR = NOP;
    tick();
    chk("ill_clr", {31'd0, illegal}, 32'd0);
    chk("ill_busy", {31'd0, busy}, 32'd0);

    // Control opcodes held during RESOLVE/HOLD are not recaptured
    issue(BEQ_M8, 32'h100, 32'd5, 32'd5);
    tick();
    IP = 32'h500; RS1_VAL = 32'd1;
    tick();
    chk("b2b_hold_amt", up_amt, 32'hFFFF_FFF8);
    chk("b2b_hold_taken", {31'd0, b_taken}, 32'd1);
    INSTR = JAL_8;
    tick();
    chk("b2b_idle_busy", {31'd0, busy}, 32'd0);
    chk("b2b_idle_lwe", {31'd0, link_we}, 32'd0);
    chk("b2b_idle_taken", {31'd0, b_taken}, 32'd0);
    INSTR = NOP;
    tick();
    chk("b2b_quiet", {31'd0, busy}, 32'd0);
`ifdef BRANCH_STATS_EN
    chk("stat_br_7", stat_branches, 32'd7);
    chk("stat_tk_4", stat_taken, 32'd4);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
